// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity_mode codes and parameter ranges.
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // Code 2'b11 is decoded as "no parity".
  function automatic logic par_active(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level (1).
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  import uart_pkg::*;

  logic r_meta, r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data/stop bits.
// Define UART_RX_PARITY_EN to build in the PARITY state and parity checking.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 rx_sampling_clk,
  input  logic                 rx_data_in,
  input  logic [1:0]           parity_mode,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 rx_busy
);
  import uart_pkg::*;

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);

  logic                 w_rx;
  rx_state_t            r_state;
  logic [TW-1:0]        r_tick;
  logic [3:0]           r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_done;
  logic                 r_ferr;
  logic                 r_ferr_out;
  logic                 r_wait_high;

  uart_sync2 u_sync (
    .clk (sys_clk),
    .rst (rst),
    .d   (rx_data_in),
    .q   (w_rx)
  );

`ifdef UART_RX_PARITY_EN
  logic [1:0] r_par_mode;
  logic       r_perr;
  logic       r_perr_out;
`else
  logic       w_unused_parity;
  assign w_unused_parity = ^parity_mode;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tick      <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_dout      <= '0;
      r_done      <= 1'b0;
      r_ferr      <= 1'b0;
      r_ferr_out  <= 1'b0;
      r_wait_high <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_mode  <= PAR_NONE;
      r_perr      <= 1'b0;
      r_perr_out  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (rx_sampling_clk) begin
        unique case (r_state)
          // After a frame ending on a low stop sample (e.g. break), wait for the line to go high.
          ST_IDLE: begin
            if (w_rx) begin
              r_wait_high <= 1'b0;
            end else if (!r_wait_high) begin
              r_state <= ST_START;
              r_tick  <= '0;
              r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
              r_par_mode <= parity_mode;
              r_perr     <= 1'b0;
`endif
            end
          end
          ST_START: begin
            if (r_tick == HALF_M1) begin
              r_tick   <= '0;
              r_bitcnt <= '0;
              r_state  <= w_rx ? ST_IDLE : ST_DATA;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          ST_DATA: begin
            if (r_tick == FULL_M1) begin
              r_tick  <= '0;
              r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
              if (r_bitcnt == DB_M1) begin
                r_bitcnt <= '0;
`ifdef UART_RX_PARITY_EN
                r_state  <= par_active(r_par_mode) ? ST_PARITY : ST_STOP;
`else
                r_state  <= ST_STOP;
`endif
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (r_tick == FULL_M1) begin
              r_tick  <= '0;
              r_perr  <= (^r_shift) ^ w_rx ^ (r_par_mode == PAR_ODD);
              r_state <= ST_STOP;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (r_tick == FULL_M1) begin
              r_tick <= '0;
              if (!w_rx) r_ferr <= 1'b1;
              if (r_bitcnt == SB_M1) begin
                r_state     <= ST_IDLE;
                r_bitcnt    <= '0;
                r_done      <= 1'b1;
                r_dout      <= r_shift;
                r_ferr_out  <= r_ferr | ~w_rx;
                r_wait_high <= ~w_rx;
`ifdef UART_RX_PARITY_EN
                r_perr_out  <= r_perr;
`endif
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign frame_err    = r_ferr_out;
  assign rx_busy      = (r_state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err   = r_perr_out;
`else
  assign parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and a 7-data/2-stop instance.
module tb_uart_rx_param;
  localparam int OS   = 16;
  localparam int TDIV = 4;
  localparam int BIT  = OS * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] dout;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic       line8 = 1'b1, line7 = 1'b1;
  logic [1:0] pm8 = 2'b00, pm7 = 2'b00;
  logic [7:0] dout8;
  logic [6:0] dout7;
  logic       done8, done7, fe8, fe7, pe8, pe7, busy8, busy7;
  int         checks = 0, errors = 0, tcnt = 0;
  exp_t       q8[$], q7[$];
  exp_t       e8, e7;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tick = (tcnt == 0);
    tcnt = (tcnt == TDIV - 1) ? 0 : tcnt + 1;
  end

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(1)) u_dut8 (
    .sys_clk(clk), .rst(rst), .rx_sampling_clk(tick), .rx_data_in(line8),
    .parity_mode(pm8), .rx_dout(dout8), .rx_done_tick(done8),
    .frame_err(fe8), .parity_err(pe8), .rx_busy(busy8)
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(OS), .STOP_BITS(2)) u_dut7 (
    .sys_clk(clk), .rst(rst), .rx_sampling_clk(tick), .rx_data_in(line7),
    .parity_mode(pm7), .rx_dout(dout7), .rx_done_tick(done7),
    .frame_err(fe7), .parity_err(pe7), .rx_busy(busy7)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut8_unexpected_done got dout=%0h ferr=%0b exp no frame", dout8, fe8);
      end else begin
        e8 = q8.pop_front();
        chk("dut8_frame{dout,ferr,perr}", 32'({1'b0, dout8, fe8, pe8}), 32'(e8));
      end
    end
    if (done7) begin
      if (q7.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut7_unexpected_done got dout=%0h ferr=%0b exp no frame", dout7, fe7);
      end else begin
        e7 = q7.pop_front();
        chk("dut7_frame{dout,ferr,perr}", 32'({2'b00, dout7, fe7, pe7}), 32'(e7));
      end
    end
  end

  task automatic put(input bit w, input logic b, input int n);
    if (w) line7 = b; else line8 = b;
    repeat (n) @(negedge clk);
  endtask

  // Reference: received word = data bits, frame error = any stop bit low,
  // parity error = XOR(data, parity bit), inverted for odd; the mode is taken at frame start.
  task automatic send(input bit w, input logic [8:0] data, input logic [1:0] mode,
                      input logic pbit, input logic [1:0] stops);
    int         nb, ns;
    logic [8:0] d;
    bit         usep;
    exp_t       e;
    nb   = w ? 7 : 8;
    ns   = w ? 2 : 1;
    d    = data & ((9'd1 << nb) - 9'd1);
    usep = PAR_EN && (mode == 2'b01 || mode == 2'b10);
    e.dout = d;
    e.ferr = !stops[0] || (ns == 2 && !stops[1]);
    e.perr = usep ? ((^d) ^ pbit ^ (mode == 2'b10)) : 1'b0;
    if (w) begin pm7 = mode; q7.push_back(e); end
    else   begin pm8 = mode; q8.push_back(e); end
    put(w, 1'b0, BIT);
    if (w) pm7 = 2'($urandom); else pm8 = 2'($urandom);
    for (int i = 0; i < nb; i++) put(w, d[i], BIT);
    if (usep) put(w, pbit, BIT);
    for (int i = 0; i < ns; i++) put(w, stops[i], BIT);
    put(w, 1'b1, 2 * BIT);
  endtask

  initial begin
    exp_t eb;
    int   n;
    repeat (4) @(negedge clk);
    chk("reset_dut8{dout,done,ferr,perr,busy}", 32'({dout8, done8, fe8, pe8, busy8}), 32'd0);
    chk("reset_dut7{dout,done,ferr,perr,busy}", 32'({dout7, done7, fe7, pe7, busy7}), 32'd0);
    rst = 1'b0;
    repeat (2 * BIT) @(negedge clk);

    send(1'b0, 9'h9A, 2'b00, 1'b0, 2'b11);
    send(1'b0, 9'h9A, 2'b01, 1'b1, 2'b11);
    send(1'b0, 9'h9A, 2'b01, 1'b0, 2'b11);
    send(1'b0, 9'h55, 2'b00, 1'b0, 2'b10);
    send(1'b0, 9'h3C, 2'b00, 1'b0, 2'b11);

    // 4-tick low glitch: false start, no frame
    put(1'b0, 1'b0, 4 * TDIV);
    chk("glitch_busy_seen", 32'(busy8), 32'd1);
    line8 = 1'b1;
    n = 0;
    while (busy8 && n < (OS/2 + 2) * TDIV) begin @(negedge clk); n++; end
    chk("glitch_busy_cleared", 32'(busy8), 32'd0);
    repeat (2 * BIT) @(negedge clk);

    // reset in the middle of data bit 3
    put(1'b0, 1'b0, BIT);
    put(1'b0, 1'b1, BIT);
    put(1'b0, 1'b0, BIT);
    put(1'b0, 1'b1, BIT);
    put(1'b0, 1'b1, BIT / 2);
    chk("busy_before_reset", 32'(busy8), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_midframe{dout,done,ferr,perr,busy}", 32'({dout8, done8, fe8, pe8, busy8}), 32'd0);
    rst = 1'b0;
    put(1'b0, 1'b1, 2 * BIT);
    send(1'b0, 9'hA5, 2'b00, 1'b0, 2'b11);

    // break: one all-zero frame with frame error, then idle while low
    pm8 = 2'b00;
    eb.dout = 9'd0; eb.ferr = 1'b1; eb.perr = 1'b0;
    q8.push_back(eb);
    put(1'b0, 1'b0, 12 * BIT);
    chk("break_idle_busy", 32'(busy8), 32'd0);
    put(1'b0, 1'b0, 8 * BIT);
    put(1'b0, 1'b1, 2 * BIT);

    send(1'b1, 9'h41, 2'b10, 1'b1, 2'b11);
    send(1'b1, 9'h41, 2'b10, 1'b1, 2'b01);

    for (int i = 0; i < 14; i++)
      send(1'b0, 9'($urandom), 2'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);
    for (int i = 0; i < 10; i++)
      send(1'b1, 9'($urandom), 2'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);

    n = 0;
    while ((q8.size() != 0 || q7.size() != 0) && n < 4000) begin @(negedge clk); n++; end
    chk("drain_q8_outstanding", 32'(q8.size()), 32'd0);
    chk("drain_q7_outstanding", 32'(q7.size()), 32'd0);
    chk("final_idle{busy8,busy7}", 32'({busy8, busy7}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
